// File: rtl/regfile_wb_queue.sv
// Write-back queue for the 8-entry register file.
// Arbitrates ALU/load results into an in-order FIFO that drains into the single write port.

module wbq_entry_match #(
  parameter int AW = 3
) (
  input  logic          vld,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] q0addr,
  input  logic [AW-1:0] q1addr,
  output logic          hit0,
  output logic          hit1
);
  assign hit0 = vld && (addr == q0addr);
  assign hit1 = vld && (addr == q1addr);
endmodule

module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          wb_stall,
  output logic          wea,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] q0addr,
  output logic          q0busy,
  input  logic [AW-1:0] q1addr,
  output logic          q1busy,
  output logic [AW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {SRC_ALU, SRC_LD} src_e;

  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            cnt;
  src_e                     rr_last;

  logic          full, grant_alu, grant_ld, push, pop;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;

  // On a tie, the producer that did not win last time gets the slot.
  assign full      = (cnt == CW'(DEPTH));
  assign grant_alu = alu_valid && (!ld_valid || rr_last == SRC_LD);
  assign grant_ld  = ld_valid && (!alu_valid || rr_last == SRC_ALU);
  assign alu_ready = grant_alu && !full && !reset;
  assign ld_ready  = grant_ld && !full && !reset;
  assign push      = alu_ready || ld_ready;
  assign push_addr = ld_ready ? ld_addr : alu_addr;
  assign push_data = ld_ready ? ld_data : alu_data;

  assign wea   = (cnt != '0) && !wb_stall;
  assign pop   = wea;
  assign waddr = (cnt != '0) ? ent_addr[rd_ptr] : '0;
  assign wdata = (cnt != '0) ? ent_data[rd_ptr] : '0;
  assign count = AW'(cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_addr <= '0;
      ent_data <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      rr_last  <= SRC_LD;
    end else begin
      if (push) begin
        ent_addr[wr_ptr] <= push_addr;
        ent_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
        rr_last          <= ld_ready ? SRC_LD : SRC_ALU;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Occupancy is judged from the ring offset, so the head stays busy until it actually pops.
  logic [DEPTH-1:0] hit0, hit1;
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    logic          vld;
    assign off = PW'(i) - rd_ptr;
    assign vld = CW'(off) < cnt;
    wbq_entry_match #(.AW(AW)) u_match (
      .vld   (vld),
      .addr  (ent_addr[i]),
      .q0addr(q0addr),
      .q1addr(q1addr),
      .hit0  (hit0[i]),
      .hit1  (hit1[i])
    );
  end

  assign q0busy = |hit0;
  assign q1busy = |hit1;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic against a queue-based model.

module tb_regfile_wb_queue;
  localparam int DEPTH = 4, DW = 32, AW = 3;

  logic clk = 0, reset = 1;
  logic alu_valid = 0, ld_valid = 0, wb_stall = 0;
  logic [AW-1:0] alu_addr = 0, ld_addr = 0, q0addr = 0, q1addr = 0;
  logic [DW-1:0] alu_data = 0, ld_data = 0;
  logic alu_ready, ld_ready, wea, q0busy, q1busy;
  logic [AW-1:0] waddr, count;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .wb_stall(wb_stall), .wea(wea), .waddr(waddr), .wdata(wdata),
    .q0addr(q0addr), .q0busy(q0busy), .q1addr(q1addr), .q1busy(q1busy),
    .count(count)
  );

  // register file as written by the DUT
  logic [DW-1:0] tb_rf [8];
  always @(posedge clk) if (wea) tb_rf[waddr] <= wdata;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          mq[$];
  bit            m_last_ld;
  logic [DW-1:0] m_rf [8];

  int n_cmp = 0, n_err = 0;
  int seen_alu = 0, seen_ld = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit av, input int aa, input logic [DW-1:0] ad,
                       input bit lv, input int la, input logic [DW-1:0] ld, input bit st);
    alu_valid = av; alu_addr = AW'(aa); alu_data = ad;
    ld_valid = lv; ld_addr = AW'(la); ld_data = ld; wb_stall = st;
  endtask

  // one clock: check combinational outputs against the model, then advance the model
  task automatic cycle();
    bit full, ga, gl, e_ar, e_lr, e_we, b0, b1;
    @(negedge clk);
    full = (mq.size() == DEPTH);
    ga   = alu_valid && (!ld_valid || m_last_ld);
    gl   = ld_valid && (!alu_valid || !m_last_ld);
    e_ar = ga && !full;
    e_lr = gl && !full;
    e_we = (mq.size() != 0) && !wb_stall;
    b0 = 0; b1 = 0;
    foreach (mq[i]) begin
      if (mq[i].a == q0addr) b0 = 1;
      if (mq[i].a == q1addr) b1 = 1;
    end
    chk("alu_ready", alu_ready, e_ar);
    chk("ld_ready", ld_ready, e_lr);
    chk("wea", wea, e_we);
    chk("waddr", waddr, mq.size() ? mq[0].a : 0);
    chk("wdata", wdata, mq.size() ? mq[0].d : 0);
    chk("q0busy", q0busy, b0);
    chk("q1busy", q1busy, b1);
    chk("count", count, mq.size());
    if (alu_ready) seen_alu++;
    if (ld_ready) seen_ld++;
    @(posedge clk);
    if (e_we) begin
      m_rf[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    if (e_ar) begin mq.push_back('{alu_addr, alu_data}); m_last_ld = 0; end
    if (e_lr) begin mq.push_back('{ld_addr, ld_data}); m_last_ld = 1; end
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_wea", wea, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_q0busy", q0busy, 0);
    chk("rst_q1busy", q1busy, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    mq.delete();
    m_last_ld = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin tb_rf[i] = 0; m_rf[i] = 0; end
    m_last_ld = 1;
    #100;
    do_reset();

    // 1: single ALU write, one-cycle latency to the register file
    drive(1, 0, 32'hAAAABBBB, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("t1_count", count, 0);
    chk("t1_r0", tb_rf[0], 32'hAAAABBBB);

    // 2 + 6: fill under stall, refused 5th push, release from full
    drive(1, 1, 32'hBBBBCCCC, 0, 0, 0, 1); cycle();
    drive(1, 2, 32'hCCCCDDDD, 0, 0, 0, 1); cycle();
    drive(1, 3, 32'hDDDDAAAA, 0, 0, 0, 1); cycle();
    drive(1, 4, 32'hEEEEFFFF, 0, 0, 0, 1); cycle();
    chk("t2_full", count, 4);
    drive(1, 5, 32'h55555555, 0, 0, 0, 1); cycle(); cycle();
    drive(1, 5, 32'h55555555, 0, 0, 0, 0);
    #1 chk("t6_full_pop_noready", alu_ready, 0);
    cycle();
    chk("t6_after_pop_ready", alu_ready, 1);
    chk("t6_count3", count, 3);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (5) cycle();
    chk("t2_r4", tb_rf[4], 32'hEEEEFFFF);
    chk("t2_r5", tb_rf[5], 32'h55555555);

    // 3: tie arbitration from reset
    do_reset();
    seen_alu = 0; seen_ld = 0;
    drive(1, 1, 32'h1, 1, 2, 32'h2, 0);
    repeat (4) cycle();
    chk("t3_alu_grants", seen_alu, 2);
    chk("t3_ld_grants", seen_ld, 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();

    // 4: two writes to r3, hazard held until both retire
    q0addr = 3; q1addr = 5;
    drive(1, 3, 32'h11111111, 0, 0, 0, 1); cycle();
    drive(1, 3, 32'h22222222, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 1); cycle(); cycle();
    chk("t4_busy_stalled", q0busy, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    chk("t4_r3", tb_rf[3], 32'h22222222);

    // 5: async reset with 3 entries pending
    drive(1, 6, 32'h66666666, 0, 0, 0, 1); cycle();
    drive(1, 7, 32'h77777777, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 1, 6, 32'h68686868, 1); cycle();
    q0addr = 6; q1addr = 7;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    repeat (3) cycle();
    chk("t5_r6_untouched", tb_rf[6], m_rf[6]);
    chk("t5_r7_untouched", tb_rf[7], m_rf[7]);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            ($urandom_range(0, 9) < 3));
      q0addr = AW'($urandom_range(0, 7));
      q1addr = AW'($urandom_range(0, 7));
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (6) cycle();
    for (int i = 0; i < 8; i++) chk($sformatf("rf_r%0d", i), tb_rf[i], m_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
